// File: rtl/comb_circ_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : comb_circ_sequencer
// Purpose  : Self-test controller for a 3-input combinational block (A,B,C->X).
//            On start it sweeps all eight input vectors in the order
//            {A,B,C} = 000,010,001,011,100,110,101,111. Each vector is held for
//            SETTLE_CYCLES clocks before X is sampled. The sampled values form
//            an 8-bit truth table, which is compared against EXPECTED.
// Ports    : clk       - system clock, rising edge
//            rst_n     - synchronous active-low reset
//            start     - begin a sweep (honoured only while idle)
//            A, B, C   - registered drives to the block under test
//            X         - output of the block under test
//            busy      - sweep in progress (cycle after accept .. DONE)
//            done      - one-cycle pulse when the sweep finishes
//            pass      - truth table matched EXPECTED (valid with done, held)
//            table_out - captured truth table, bit index {A,B,C}
//            fail_idx  - {A,B,C} of the first mismatching vector, 0 if none
// Params   : SETTLE_CYCLES (1..15), EXPECTED (golden table)
// Options  : HALT_ON_MISMATCH_EN - stop the sweep at the first mismatch
// Revision : 1.0 - initial release
// ============================================================================
module comb_circ_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECTED      = 8'hBA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       C,
    input  logic       X,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] table_out,
    output logic [2:0] fail_idx
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Counter counts down to zero inclusive, so load one less than the hold time.
    localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic       r_a;
    logic       r_b;
    logic       r_c;
    logic       r_busy;
    logic       r_pass;
    logic       r_mismatch;
    logic [7:0] r_table;
    logic [2:0] r_fail_idx;

    logic [2:0] w_abc;
    logic       w_bit_bad;
    logic       w_finish;

    assign w_abc     = {r_a, r_b, r_c};
    assign w_bit_bad = (X != EXPECTED[w_abc]);

    // Sweep ends after the last vector, or at the first mismatch when halting.
    always_comb begin
        w_finish = (r_idx == 3'd7);
`ifdef HALT_ON_MISMATCH_EN
        if (w_bit_bad) begin
            w_finish = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_state_next = w_finish ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: drives, settle counter, truth-table capture and verdict
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= 3'd0;
            r_cnt      <= 4'd0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_c        <= 1'b0;
            r_busy     <= 1'b0;
            r_pass     <= 1'b0;
            r_mismatch <= 1'b0;
            r_table    <= 8'h00;
            r_fail_idx <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx      <= 3'd0;
                        r_busy     <= 1'b1;
                        r_pass     <= 1'b0;
                        r_mismatch <= 1'b0;
                        r_table    <= 8'h00;
                        r_fail_idx <= 3'd0;
                    end
                end
                S_DRIVE: begin
                    // {A,C} form the outer count, B toggles fastest.
                    r_a   <= r_idx[2];
                    r_c   <= r_idx[1];
                    r_b   <= r_idx[0];
                    r_cnt <= c_settle_load;
                end
                S_SETTLE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    r_table[w_abc] <= X;
                    if (w_bit_bad && !r_mismatch) begin
                        r_mismatch <= 1'b1;
                        r_fail_idx <= w_abc;
                    end
                    if (w_finish) begin
                        // Verdict is registered on entry so it is valid alongside done.
                        r_pass <= ~(r_mismatch | w_bit_bad);
                        r_a    <= 1'b0;
                        r_b    <= 1'b0;
                        r_c    <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                S_DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign C         = r_c;
    assign busy      = r_busy;
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;
    assign table_out = r_table;
    assign fail_idx  = r_fail_idx;

endmodule
`default_nettype wire

// File: tb/tb_comb_circ_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_comb_circ_sequencer
// Purpose  : Self-checking bench for comb_circ_sequencer. One instance with the
//            default settle time is exercised against several models of the
//            block under test; a second instance with SETTLE_CYCLES=4 sees X
//            glitching during the settle window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comb_circ_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start2, start4;
    logic       a2, b2, c2, x2, busy2, done2, pass2;
    logic [7:0] table2;
    logic [2:0] fidx2;
    logic       a4, b4, c4, x4, busy4, done4, pass4;
    logic [7:0] table4;
    logic [2:0] fidx4;
    int         model;
    logic       glitch;

    int n_pass  = 0;
    int n_total = 0;

    // results captured by run_sweep
    int         res_done_cyc;
    int         res_n_done;
    logic       res_busy_c1;
    logic       res_busy_done;
    logic       res_busy_after;
    logic [2:0] res_abc_done;
    logic       res_pass_done;
    logic       res_pass_after;
    logic [7:0] res_table_done;
    logic [2:0] res_fidx_done;
    logic [2:0] drv_order[8];

    typedef struct {
        int         model;
        int         done_cyc;
        logic       pass;
        logic [7:0] tbl;
        logic [2:0] fidx;
    } vec_t;

    vec_t vecs[6];

    comb_circ_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .A(a2), .B(b2), .C(c2), .X(x2),
        .busy(busy2), .done(done2), .pass(pass2),
        .table_out(table2), .fail_idx(fidx2)
    );

    comb_circ_sequencer #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .A(a4), .B(b4), .C(c4), .X(x4),
        .busy(busy4), .done(done4), .pass(pass4),
        .table_out(table4), .fail_idx(fidx4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Models of the block under test
    always_comb begin
        case (model)
            0:       x2 = (a2 & ~b2) | c2;
            1:       x2 = 1'b0;
            2:       x2 = 1'b1;
            3:       x2 = ~((a2 & ~b2) | c2);
            4:       x2 = a2 | c2;
            5:       x2 = a2 & ~b2;
            default: x2 = 1'b0;
        endcase
    end
    assign x4 = ((a4 & ~b4) | c4) ^ glitch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Start a sweep on one instance and observe it cycle by cycle.
    // Cycle 1 is the period after the edge that samples start.
    task automatic run_sweep(input bit use4, input int restart_at, input int abort_at);
        int cyc;
        logic d, bz;
        res_done_cyc = 0; res_n_done = 0; res_busy_c1 = 1'b0;
        res_busy_done = 1'b0; res_busy_after = 1'b1; res_abc_done = 3'b111;
        res_pass_done = 1'b0; res_pass_after = 1'b0;
        res_table_done = 8'h55; res_fidx_done = 3'b111;
        for (int k = 0; k < 8; k++) drv_order[k] = 3'bxxx;
        @(negedge clk);
        if (use4) start4 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        cyc = 0;
        while (cyc < 120 && (res_done_cyc == 0 || cyc < res_done_cyc + 2)) begin
            @(negedge clk);
            cyc++;
            start2 = 1'b0;
            start4 = 1'b0;
            glitch = use4 && (cyc % 6 != 0);
            if (cyc == restart_at) begin
                if (use4) start4 = 1'b1; else start2 = 1'b1;
            end
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                glitch = 1'b0;
                return;
            end
            d  = use4 ? done4 : done2;
            bz = use4 ? busy4 : busy2;
            if (cyc == 1) res_busy_c1 = bz;
            if (!use4 && cyc >= 4 && cyc <= 32 && (cyc % 4 == 0))
                drv_order[cyc / 4 - 1] = {a2, b2, c2};
            if (d) begin
                res_n_done++;
                if (res_done_cyc == 0) begin
                    res_done_cyc   = cyc;
                    res_busy_done  = bz;
                    res_abc_done   = use4 ? {a4, b4, c4} : {a2, b2, c2};
                    res_pass_done  = use4 ? pass4 : pass2;
                    res_table_done = use4 ? table4 : table2;
                    res_fidx_done  = use4 ? fidx4 : fidx2;
                end
            end
            if (res_done_cyc != 0 && cyc == res_done_cyc + 1) begin
                res_busy_after = bz;
                res_pass_after = use4 ? pass4 : pass2;
            end
        end
        glitch = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_order[8];
        exp_order = '{3'b000, 3'b010, 3'b001, 3'b011, 3'b100, 3'b110, 3'b101, 3'b111};
`ifdef HALT_ON_MISMATCH_EN
        vecs[0] = '{0, 33, 1'b1, 8'hBA, 3'd0};
        vecs[1] = '{1, 13, 1'b0, 8'h00, 3'd1};
        vecs[2] = '{2,  5, 1'b0, 8'h01, 3'd0};
        vecs[3] = '{3,  5, 1'b0, 8'h01, 3'd0};
        vecs[4] = '{4, 25, 1'b0, 8'h5A, 3'd6};
        vecs[5] = '{5, 13, 1'b0, 8'h00, 3'd1};
`else
        vecs[0] = '{0, 33, 1'b1, 8'hBA, 3'd0};
        vecs[1] = '{1, 33, 1'b0, 8'h00, 3'd1};
        vecs[2] = '{2, 33, 1'b0, 8'hFF, 3'd0};
        vecs[3] = '{3, 33, 1'b0, 8'h45, 3'd0};
        vecs[4] = '{4, 33, 1'b0, 8'hFA, 3'd6};
        vecs[5] = '{5, 33, 1'b0, 8'h30, 3'd1};
`endif
        rst_n = 1'b0; start2 = 1'b0; start4 = 1'b0; model = 0; glitch = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_abc",   {a2, b2, c2}, 3'b000);
        check("reset_busy",  busy2, 1'b0);
        check("reset_done",  done2, 1'b0);
        check("reset_pass",  pass2, 1'b0);
        check("reset_table", table2, 8'h00);
        check("reset_fidx",  fidx2, 3'd0);
        rst_n = 1'b1;

        // Full sweeps against each model
        for (int i = 0; i < 6; i++) begin
            model = vecs[i].model;
            run_sweep(1'b0, 0, 0);
            check($sformatf("m%0d_done_cyc", model), res_done_cyc, vecs[i].done_cyc);
            check($sformatf("m%0d_n_done", model), res_n_done, 1);
            check($sformatf("m%0d_pass", model), res_pass_done, vecs[i].pass);
            check($sformatf("m%0d_table", model), res_table_done, vecs[i].tbl);
            check($sformatf("m%0d_fidx", model), res_fidx_done, vecs[i].fidx);
            check($sformatf("m%0d_busy_c1", model), res_busy_c1, 1'b1);
            check($sformatf("m%0d_busy_in_done", model), res_busy_done, 1'b1);
            check($sformatf("m%0d_busy_after", model), res_busy_after, 1'b0);
            check($sformatf("m%0d_abc_in_done", model), res_abc_done, 3'b000);
            check($sformatf("m%0d_pass_held", model), res_pass_after, vecs[i].pass);
            if (model == 0) begin
                for (int k = 0; k < 8; k++)
                    check($sformatf("drive_order_%0d", k), drv_order[k], exp_order[k]);
            end
        end

        // start pulsed mid-sweep is ignored
        model = 0;
        run_sweep(1'b0, 10, 0);
        check("restart_done_cyc", res_done_cyc, 33);
        check("restart_n_done",   res_n_done, 1);
        check("restart_pass",     res_pass_done, 1'b1);
        check("restart_table",    res_table_done, 8'hBA);
        check("restart_fidx",     res_fidx_done, 3'd0);

        // Reset mid-sweep, then a fresh sweep
        model = 1;
        run_sweep(1'b0, 0, 10);
        check("midrst_abc",   {a2, b2, c2}, 3'b000);
        check("midrst_busy",  busy2, 1'b0);
        check("midrst_done",  done2, 1'b0);
        check("midrst_pass",  pass2, 1'b0);
        check("midrst_table", table2, 8'h00);
        check("midrst_fidx",  fidx2, 3'd0);
        rst_n = 1'b1;
        model = 0;
        run_sweep(1'b0, 0, 0);
        check("postrst_done_cyc", res_done_cyc, 33);
        check("postrst_pass",     res_pass_done, 1'b1);
        check("postrst_table",    res_table_done, 8'hBA);

        // Longer settle with X glitching during the settle window
        run_sweep(1'b1, 0, 0);
        check("settle4_done_cyc", res_done_cyc, 49);
        check("settle4_n_done",   res_n_done, 1);
        check("settle4_pass",     res_pass_done, 1'b1);
        check("settle4_table",    res_table_done, 8'hBA);
        check("settle4_fidx",     res_fidx_done, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
